// File: rtl/seq_divider_4x8.sv
// ============================================================================
// Module   : seq_divider_4x8
// Purpose  : Sequential restoring divider, 8-bit dividend / 4-bit divisor,
//            one quotient bit per clock with a start/busy/done handshake.
// Revision : 1.0 - initial release
// ============================================================================
`default_nettype none

module seq_divider_4x8 (
    input  logic       clk,
    input  logic       rst,
    input  logic       start,
    input  logic [7:0] dividend,
    input  logic [3:0] divisor,
    output logic       busy,
    output logic       done,
    output logic [7:0] quotient,
    output logic [3:0] remainder,
    output logic       div_by_zero
);

    typedef enum logic [1:0] {
        S_IDLE = 2'd0,
        S_CALC = 2'd1,
        S_DONE = 2'd2
    } state_t;

    state_t     state_q, state_d;
    logic [7:0] dq_q, dq_d;
    logic [3:0] div_q, div_d;
    logic [3:0] work_q, work_d;
    logic [2:0] cnt_q, cnt_d;
    logic       busy_q, busy_d;
    logic       done_q, done_d;
    logic [7:0] quotient_q, quotient_d;
    logic [3:0] remainder_q, remainder_d;
    logic       dbz_q, dbz_d;

    logic [4:0] w_trial;
    logic       w_ge;
    logic [7:0] w_dq_next;
    logic [3:0] w_work_next;

    // The restored remainder is always below the divisor, so a 4-bit
    // subtraction is exact even when the 5-bit trial value is 16 or more.
    always_comb begin
        w_trial     = {work_q, dq_q[7]};
        w_ge        = (w_trial >= {1'b0, div_q});
        w_dq_next   = {dq_q[6:0], w_ge};
        w_work_next = w_ge ? (w_trial[3:0] - div_q) : w_trial[3:0];
    end

    always_comb begin
        state_d     = state_q;
        dq_d        = dq_q;
        div_d       = div_q;
        work_d      = work_q;
        cnt_d       = cnt_q;
        busy_d      = busy_q;
        done_d      = done_q;
        quotient_d  = quotient_q;
        remainder_d = remainder_q;
        dbz_d       = dbz_q;
        case (state_q)
            S_IDLE: begin
                if (start) begin
                    if (divisor != 4'h0) begin
                        dq_d    = dividend;
                        div_d   = divisor;
                        work_d  = 4'h0;
                        cnt_d   = 3'd0;
                        busy_d  = 1'b1;
                        state_d = S_CALC;
                    end else begin
                        quotient_d  = 8'hFF;
                        remainder_d = 4'h0;
                        dbz_d       = 1'b1;
                        done_d      = 1'b1;
                        state_d     = S_DONE;
                    end
                end
            end
            S_CALC: begin
                dq_d   = w_dq_next;
                work_d = w_work_next;
                cnt_d  = cnt_q + 3'd1;
                if (cnt_q == 3'd7) begin
                    quotient_d  = w_dq_next;
                    remainder_d = w_work_next;
                    dbz_d       = 1'b0;
                    busy_d      = 1'b0;
                    done_d      = 1'b1;
                    state_d     = S_DONE;
                end
            end
            S_DONE: begin
                done_d  = 1'b0;
                state_d = S_IDLE;
            end
            default: begin
                busy_d  = 1'b0;
                done_d  = 1'b0;
                state_d = S_IDLE;
            end
        endcase
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q     <= S_IDLE;
            dq_q        <= 8'h00;
            div_q       <= 4'h0;
            work_q      <= 4'h0;
            cnt_q       <= 3'd0;
            busy_q      <= 1'b0;
            done_q      <= 1'b0;
            quotient_q  <= 8'h00;
            remainder_q <= 4'h0;
            dbz_q       <= 1'b0;
        end else begin
            state_q     <= state_d;
            dq_q        <= dq_d;
            div_q       <= div_d;
            work_q      <= work_d;
            cnt_q       <= cnt_d;
            busy_q      <= busy_d;
            done_q      <= done_d;
            quotient_q  <= quotient_d;
            remainder_q <= remainder_d;
            dbz_q       <= dbz_d;
        end
    end

    assign busy        = busy_q;
    assign done        = done_q;
    assign quotient    = quotient_q;
    assign remainder   = remainder_q;
    assign div_by_zero = dbz_q;

endmodule

`default_nettype wire

// File: tb/tb_seq_divider_4x8.sv
// ============================================================================
// Module   : tb_seq_divider_4x8
// Purpose  : Directed and exhaustive self-checking bench for seq_divider_4x8.
// Revision : 1.0 - initial release
// ============================================================================
`default_nettype none

module tb_seq_divider_4x8;

    logic       clk;
    logic       rst;
    logic       start;
    logic [7:0] dividend;
    logic [3:0] divisor;
    logic       busy;
    logic       done;
    logic [7:0] quotient;
    logic [3:0] remainder;
    logic       div_by_zero;

    int n_checks;
    int n_fail;

    seq_divider_4x8 dut (
        .clk         (clk),
        .rst         (rst),
        .start       (start),
        .dividend    (dividend),
        .divisor     (divisor),
        .busy        (busy),
        .done        (done),
        .quotient    (quotient),
        .remainder   (remainder),
        .div_by_zero (div_by_zero)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0d expected %0d", tag, act, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    // Issue one start and wait for done. inj >= 0 pulses a second start with
    // different operands that many cycles into the operation.
    task automatic run_op(input logic [7:0] a, input logic [3:0] b, input int inj);
        int          cyc;
        int          nb;
        logic [7:0]  eq;
        logic [3:0]  er;
        dividend = a;
        divisor  = b;
        start    = 1'b1;
        tick();
        start    = 1'b0;
        dividend = 8'h5A;
        divisor  = 4'h0;
        cyc = 0;
        nb  = 0;
        while (!done && cyc < 20) begin
            if (busy) nb++;
            if (cyc == inj) begin
                start    = 1'b1;
                dividend = 8'd50;
                divisor  = 4'd2;
            end else begin
                start = 1'b0;
            end
            tick();
            cyc++;
        end
        start = 1'b0;
        eq = (b == 4'h0) ? 8'hFF : a / {4'h0, b};
        er = (b == 4'h0) ? 4'h0  : 4'((a % {4'h0, b}));
        chk("latency",     cyc,         (b == 4'h0) ? 0 : 8);
        chk("busy_cycles", nb,          (b == 4'h0) ? 0 : 8);
        chk("quotient",    quotient,    eq);
        chk("remainder",   remainder,   er);
        chk("div_by_zero", div_by_zero, (b == 4'h0) ? 1 : 0);
        tick();
        chk("done_one_cycle", done, 0);
        chk("busy_after",     busy, 0);
    endtask

    initial begin
        n_checks = 0;
        n_fail   = 0;
        rst      = 1'b1;
        start    = 1'b0;
        dividend = 8'h00;
        divisor  = 4'h0;
        tick();
        tick();
        chk("rst_busy", busy, 0);
        chk("rst_done", done, 0);
        chk("rst_q",    quotient, 0);
        chk("rst_r",    remainder, 0);
        chk("rst_dbz",  div_by_zero, 0);
        rst = 1'b0;
        tick();

        run_op(8'd200, 4'd7, -1);
        run_op(8'd255, 4'd1, -1);
        run_op(8'd5,   4'd9, -1);
        run_op(8'd0,   4'd15, -1);
        run_op(8'd255, 4'd15, -1);
        run_op(8'd42,  4'd0, -1);
        run_op(8'd42,  4'd5, -1);

        // Start ignored while busy: result stays 100/3, no extra done.
        run_op(8'd100, 4'd3, 4);
        begin
            int extra;
            extra = 0;
            for (int i = 0; i < 12; i++) begin
                if (done) extra++;
                tick();
            end
            chk("no_second_done", extra, 0);
        end

        // Asynchronous reset in the middle of iteration 5.
        dividend = 8'd100;
        divisor  = 4'd3;
        start    = 1'b1;
        tick();
        start    = 1'b0;
        for (int i = 0; i < 5; i++) tick();
        chk("busy_before_rst", busy, 1);
        #2;
        rst = 1'b1;
        #1;
        chk("arst_busy", busy, 0);
        chk("arst_done", done, 0);
        chk("arst_q",    quotient, 0);
        chk("arst_r",    remainder, 0);
        begin
            int seen;
            seen = 0;
            for (int i = 0; i < 3; i++) begin
                tick();
                if (done) seen++;
            end
            rst = 1'b0;
            for (int i = 0; i < 10; i++) begin
                tick();
                if (done || busy) seen++;
            end
            chk("no_done_after_rst", seen, 0);
        end
        run_op(8'd100, 4'd3, -1);

        // Start held high: repeated operations, each 77/6 = 12 r 5.
        dividend = 8'd77;
        divisor  = 4'd6;
        start    = 1'b1;
        for (int n = 0; n < 3; n++) begin
            int cyc;
            cyc = 0;
            while (!done && cyc < 12) begin
                tick();
                cyc++;
            end
            chk("held_done", done, 1);
            chk("held_q",    quotient, 12);
            chk("held_r",    remainder, 5);
            tick();
        end
        start = 1'b0;
        tick();
        tick();

        for (int a = 0; a < 256; a++) begin
            for (int b = 1; b < 16; b++) begin
                run_op(8'(a), 4'(b), -1);
            end
        end

        $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
        $finish;
    end

endmodule

`default_nettype wire
